// File: rtl/tagged_mem_responder.sv
// Fixed-latency tagged memory responder: grants the lowest free tag (1..15) and
// returns completions in acceptance order exactly MEM_LATENCY cycles later.
`ifndef XLEN
`define XLEN 32
`endif

module tagged_mem_responder #(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_WORDS   = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2mem_command,
  input  logic [`XLEN-1:0] proc2mem_addr,
  input  logic [63:0]      proc2mem_data,
  output logic [3:0]       mem2proc_response,
  output logic [63:0]      mem2proc_data,
  output logic [3:0]       mem2proc_tag
);
  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [63:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [15:1]      busy;
  logic             is_load;
  logic             is_store;
  logic             accept;
  logic [3:0]       grant_tag;
  logic [63:0]      rd_word;

  logic             pipe_valid [MEM_LATENCY];
  logic [3:0]       pipe_tag   [MEM_LATENCY];
  logic             pipe_load  [MEM_LATENCY];
  logic [63:0]      pipe_data  [MEM_LATENCY];

  // Low offset bits and high bits alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^proc2mem_addr;

  assign word_idx = proc2mem_addr[3 +: IDX_W];
  assign is_load  = (proc2mem_command == BUS_LOAD);
  assign is_store = (proc2mem_command == BUS_STORE);
  assign rd_word  = mem[word_idx];

  // A completing tag is still busy here, so it is never re-granted in its own cycle.
  always_comb begin
    grant_tag = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (!busy[i]) grant_tag = 4'(i);
    end
    accept            = !reset && (is_load || is_store) && (grant_tag != 4'd0);
    mem2proc_response = accept ? grant_tag : 4'd0;
  end

  // Backing store is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem[word_idx] <= proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_tag[i]   <= 4'd0;
        pipe_load[i]  <= 1'b0;
        pipe_data[i]  <= 64'd0;
      end
    end else begin
      if (pipe_valid[MEM_LATENCY-1]) busy[pipe_tag[MEM_LATENCY-1]] <= 1'b0;
      if (accept) busy[grant_tag] <= 1'b1;

      pipe_valid[0] <= accept;
      pipe_tag[0]   <= accept ? grant_tag : 4'd0;
      pipe_load[0]  <= accept && is_load;
      pipe_data[0]  <= (accept && is_load) ? rd_word : 64'd0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        pipe_load[i]  <= pipe_load[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Last pipeline stage acts as the output register; fields are masked to 0 when idle.
  assign mem2proc_tag  = pipe_valid[MEM_LATENCY-1] ? pipe_tag[MEM_LATENCY-1] : 4'd0;
  assign mem2proc_data = (pipe_valid[MEM_LATENCY-1] && pipe_load[MEM_LATENCY-1]) ?
                         pipe_data[MEM_LATENCY-1] : 64'd0;

endmodule
